// File: rtl/regset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : regset_ctrl
//  Description : Sequencer and port arbiter in front of the 64 x 33-bit
//                register set. Zero-fills every entry after reset, then
//                passes core traffic through and services single-word
//                debug reads/writes while the core is halted.
//  Revision    : 1.0 - initial release
// ============================================================================
module regset_ctrl #(
    parameter int NREGS = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rstn,
    // core side
    input  logic          core_we,
    input  logic [AW-1:0] core_wa,
    input  logic [31:0]   core_wd,
    input  logic          core_wg,
    input  logic [AW-1:0] core_ra1,
    input  logic [AW-1:0] core_ra2,
    output logic [31:0]   core_rd1,
    output logic [31:0]   core_rd2,
    output logic          core_rg1,
    output logic          core_rg2,
    output logic          core_stall,
    input  logic          core_halted,
    output logic          init_done,
    // debug side
    input  logic          dbg_req,
    input  logic          dbg_write,
    input  logic [AW-1:0] dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic          dbg_ack,
    output logic [31:0]   dbg_rdata,
    output logic          dbg_rgrubby,
    // register-set side
    output logic          rs_we,
    output logic [AW-1:0] rs_wa,
    output logic [31:0]   rs_wd,
    output logic          rs_wg,
    output logic [AW-1:0] rs_ra1,
    output logic [AW-1:0] rs_ra2,
    input  logic [31:0]   rs_rd1,
    input  logic [31:0]   rs_rd2,
    input  logic          rs_rg1,
    input  logic          rs_rg2
);

    localparam logic [1:0]    S_CLEAR  = 2'd0;
    localparam logic [1:0]    S_RUN    = 2'd1;
    localparam logic [1:0]    S_DBG    = 2'd2;
    localparam logic [AW-1:0] CNT_LAST = AW'(NREGS - 1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          init_done_q, init_done_d;
    logic          dbg_wr_q, dbg_wr_d;
    logic [AW-1:0] dbg_addr_q, dbg_addr_d;
    logic [31:0]   dbg_wdata_q, dbg_wdata_d;

    // A debug request is only taken in RUN and only while the core is halted
    logic w_accept;
    assign w_accept = (state_q == S_RUN) && dbg_req && core_halted;

    // Next-state: clear sweep, debug acceptance, single-cycle DBG return
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        dbg_wr_d    = dbg_wr_q;
        dbg_addr_d  = dbg_addr_q;
        dbg_wdata_d = dbg_wdata_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    state_d     = S_DBG;
                    dbg_wr_d    = dbg_write;
                    dbg_addr_d  = dbg_addr;
                    dbg_wdata_d = dbg_wdata;
                end
            end
            S_DBG: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset restarts the clear sweep and drops any debug ack
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_CLEAR;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            dbg_wr_q    <= 1'b0;
            dbg_addr_q  <= '0;
            dbg_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            dbg_wr_q    <= dbg_wr_d;
            dbg_addr_q  <= dbg_addr_d;
            dbg_wdata_q <= dbg_wdata_d;
        end
    end

    // Register-set port mux: core pass-through unless clearing or debugging
    always_comb begin
        rs_we  = core_we;
        rs_wa  = core_wa;
        rs_wd  = core_wd;
        rs_wg  = core_wg;
        rs_ra1 = core_ra1;
        rs_ra2 = core_ra2;
        case (state_q)
            S_CLEAR: begin
                rs_we = 1'b1;
                rs_wa = cnt_q;
                rs_wd = 32'd0;
                rs_wg = 1'b0;
            end
            S_RUN: begin
                if (w_accept) begin
                    if (dbg_write) begin
                        rs_we = 1'b1;
                        rs_wa = dbg_addr;
                        rs_wd = dbg_wdata;
                        rs_wg = 1'b0;
                    end else begin
                        rs_we  = 1'b0;
                        rs_ra1 = dbg_addr;
                    end
                end
            end
            S_DBG: begin
                // Core writes are blocked; a debug write is re-driven with the
                // latched values, which is idempotent on the register set.
                if (dbg_wr_q) begin
                    rs_we = 1'b1;
                    rs_wa = dbg_addr_q;
                    rs_wd = dbg_wdata_q;
                    rs_wg = 1'b0;
                end else begin
                    rs_we = 1'b0;
                end
            end
            default: begin
                rs_we = 1'b0;
            end
        endcase
    end

    assign core_rd1   = rs_rd1;
    assign core_rd2   = rs_rd2;
    assign core_rg1   = rs_rg1;
    assign core_rg2   = rs_rg2;
    assign core_stall = (state_q != S_RUN) || w_accept;
    assign init_done  = init_done_q;

    // Read data arrives in the DBG cycle; entry 0 always reads as zero
    assign dbg_ack     = (state_q == S_DBG);
    assign dbg_rdata   = (dbg_ack && !dbg_wr_q && (dbg_addr_q != '0)) ? rs_rd1 : 32'd0;
    assign dbg_rgrubby = (dbg_ack && !dbg_wr_q && (dbg_addr_q != '0)) ? rs_rg1 : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_regset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regset_ctrl
//  Description : Self-checking bench for regset_ctrl with a register-set
//                memory model and an array-based reference scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regset_ctrl;

    localparam int NREGS = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rstn;
    logic          core_we, core_wg, core_halted;
    logic [AW-1:0] core_wa, core_ra1, core_ra2;
    logic [31:0]   core_wd;
    logic [31:0]   core_rd1, core_rd2;
    logic          core_rg1, core_rg2, core_stall, init_done;
    logic          dbg_req, dbg_write, dbg_ack, dbg_rgrubby;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_wdata, dbg_rdata;
    logic          rs_we, rs_wg;
    logic [AW-1:0] rs_wa, rs_ra1, rs_ra2;
    logic [31:0]   rs_wd, rs_rd1, rs_rd2;
    logic          rs_rg1, rs_rg2;

    always #5 clk = ~clk;

    regset_ctrl #(.NREGS(NREGS), .AW(AW)) dut (
        .clk(clk), .rstn(rstn),
        .core_we(core_we), .core_wa(core_wa), .core_wd(core_wd), .core_wg(core_wg),
        .core_ra1(core_ra1), .core_ra2(core_ra2),
        .core_rd1(core_rd1), .core_rd2(core_rd2), .core_rg1(core_rg1), .core_rg2(core_rg2),
        .core_stall(core_stall), .core_halted(core_halted), .init_done(init_done),
        .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_rgrubby(dbg_rgrubby),
        .rs_we(rs_we), .rs_wa(rs_wa), .rs_wd(rs_wd), .rs_wg(rs_wg),
        .rs_ra1(rs_ra1), .rs_ra2(rs_ra2),
        .rs_rd1(rs_rd1), .rs_rd2(rs_rd2), .rs_rg1(rs_rg1), .rs_rg2(rs_rg2)
    );

    // Register-set memory: synchronous read, old data on collision, entry 0 fixed at zero
    logic [32:0] mem [NREGS];
    bit          scramble;
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < NREGS; i++)
                mem[i] <= (i == 0) ? 33'd0 : {1'($urandom), 32'($urandom)};
        end else if (rs_we && (rs_wa != '0)) begin
            mem[rs_wa] <= {rs_wg, rs_wd};
        end
        rs_rd1 <= mem[rs_ra1][31:0];
        rs_rg1 <= mem[rs_ra1][32];
        rs_rd2 <= mem[rs_ra2][31:0];
        rs_rg2 <= mem[rs_ra2][32];
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic idle();
        core_we = 1'b0; core_wa = '0; core_wd = '0; core_wg = 1'b0;
        core_ra1 = '0; core_ra2 = '0;
        dbg_req = 1'b0; dbg_write = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    // Reset, then follow the clear sweep; abort_at >= 0 re-asserts reset at that count
    task automatic do_reset_clear(input int abort_at);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("reset_values",
            64'({rs_we, rs_wa, init_done, core_stall, dbg_ack, dbg_rdata, dbg_rgrubby}),
            64'({1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0}));
        @(negedge clk);
        rstn = 1'b1;
        #1;
        for (int c = 0; c < NREGS; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            chk("clear_write",
                64'({rs_we, rs_wa, rs_wd, rs_wg, init_done, core_stall}),
                64'({1'b1, 6'(c), 32'd0, 1'b0, 1'b0, 1'b1}));
            if (c == abort_at) begin
                rstn = 1'b0;
                #1;
                chk("abort_restart", 64'({rs_we, rs_wa, init_done}), 64'({1'b1, 6'd0, 1'b0}));
                return;
            end
        end
        @(negedge clk);
        #1;
        chk("init_done_rise", 64'({init_done, core_stall}), 64'(2'b10));
    endtask

    typedef struct {
        logic        we;  logic [5:0] wa;  logic [31:0] wd;  logic wg;
        logic [5:0]  ra1; logic [5:0] ra2;
        logic        halted; logic req; logic dwr; logic [5:0] daddr; logic [31:0] dwd;
        logic        e_we; logic [5:0] e_wa; logic [31:0] e_wd; logic e_wg;
        logic [5:0]  e_ra1; logic [5:0] e_ra2; logic e_stall;
        logic        cmp_w;
    } vec_t;

    vec_t vecs [6];

    // Reference scoreboard for the random phase
    logic [32:0] model [NREGS];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ack_idx0, ack_idx1;
        bit  ack_due, dbg_pend, cur_wr, accept, r1_valid, r2_valid;
        logic [AW-1:0] cur_addr;
        logic [31:0]   cur_wd;
        logic [32:0]   exp_dbg, exp_r1, exp_r2;

        rstn = 1'b0;
        core_halted = 1'b0;
        scramble = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        scramble = 1'b0;

        // ---------------- reset clear ----------------
        do_reset_clear(-1);

        // ---------------- table-driven combinational mux checks ----------------
        vecs[0] = '{1'b1, 6'd5,  32'hDEADBEEF, 1'b1, 6'd3,  6'd9, 1'b0, 1'b0, 1'b0, 6'd0,  32'h0,
                    1'b1, 6'd5,  32'hDEADBEEF, 1'b1, 6'd3,  6'd9, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 6'd63, 32'h00000001, 1'b0, 6'd63, 6'd0, 1'b1, 1'b0, 1'b0, 6'd0,  32'h0,
                    1'b0, 6'd63, 32'h00000001, 1'b0, 6'd63, 6'd0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 6'd12, 32'h55AA55AA, 1'b0, 6'd1,  6'd2, 1'b0, 1'b1, 1'b1, 6'd40, 32'h12345678,
                    1'b1, 6'd12, 32'h55AA55AA, 1'b0, 6'd1,  6'd2, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 6'd5,  32'hAAAA0000, 1'b1, 6'd4,  6'd6, 1'b1, 1'b1, 1'b1, 6'd12, 32'h12345678,
                    1'b1, 6'd12, 32'h12345678, 1'b0, 6'd4,  6'd6, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 6'd5,  32'hAAAA0000, 1'b1, 6'd4,  6'd6, 1'b1, 1'b1, 1'b0, 6'd33, 32'hFFFFFFFF,
                    1'b0, 6'd0,  32'h0,        1'b0, 6'd33, 6'd6, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 6'd0,  32'hFFFFFFFF, 1'b1, 6'd0,  6'd0, 1'b1, 1'b0, 1'b0, 6'd0,  32'h0,
                    1'b1, 6'd0,  32'hFFFFFFFF, 1'b1, 6'd0,  6'd0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            core_we = vecs[i].we; core_wa = vecs[i].wa; core_wd = vecs[i].wd; core_wg = vecs[i].wg;
            core_ra1 = vecs[i].ra1; core_ra2 = vecs[i].ra2; core_halted = vecs[i].halted;
            dbg_req = vecs[i].req; dbg_write = vecs[i].dwr; dbg_addr = vecs[i].daddr; dbg_wdata = vecs[i].dwd;
            #1;
            chk($sformatf("mux_vec%0d", i),
                64'({rs_we, vecs[i].cmp_w ? {rs_wa, rs_wd, rs_wg} : 39'd0, rs_ra1, rs_ra2, core_stall}),
                64'({vecs[i].e_we, vecs[i].cmp_w ? {vecs[i].e_wa, vecs[i].e_wd, vecs[i].e_wg} : 39'd0,
                     vecs[i].e_ra1, vecs[i].e_ra2, vecs[i].e_stall}));
            idle();
        end
        core_halted = 1'b0;

        // ---------------- pass-through write then read ----------------
        @(negedge clk);
        core_we = 1'b1; core_wa = 6'd5; core_wd = 32'hDEADBEEF; core_wg = 1'b0;
        @(negedge clk);
        core_we = 1'b0; core_ra1 = 6'd5;
        @(negedge clk);
        #1;
        chk("pass_read", 64'({core_rg1, core_rd1}), 64'({1'b0, 32'hDEADBEEF}));

        // ---------------- debug read while halted ----------------
        @(negedge clk);
        core_halted = 1'b1; dbg_req = 1'b1; dbg_write = 1'b0; dbg_addr = 6'd5;
        #1;
        chk("dbgrd_accept", 64'({dbg_ack, core_stall}), 64'(2'b01));
        @(negedge clk);
        #1;
        chk("dbgrd_ack", 64'({dbg_ack, core_stall, dbg_rgrubby, dbg_rdata}),
            64'({1'b1, 1'b1, 1'b0, 32'hDEADBEEF}));
        dbg_req = 1'b0;
        @(negedge clk);
        #1;
        chk("dbgrd_after", 64'({dbg_ack, core_stall}), 64'(2'b00));

        // ---------------- grubby bit and entry 0 via debug read ----------------
        core_we = 1'b1; core_wa = 6'd20; core_wd = 32'h0BADF00D; core_wg = 1'b1;
        @(negedge clk);
        core_we = 1'b0; dbg_req = 1'b1; dbg_write = 1'b0; dbg_addr = 6'd20;
        @(negedge clk);
        #1;
        chk("dbgrd_grubby", 64'({dbg_ack, dbg_rgrubby, dbg_rdata}), 64'({1'b1, 1'b1, 32'h0BADF00D}));
        dbg_req = 1'b0;
        @(negedge clk);
        core_we = 1'b1; core_wa = 6'd0; core_wd = 32'hFFFFFFFF; core_wg = 1'b1;
        @(negedge clk);
        core_we = 1'b0; dbg_req = 1'b1; dbg_write = 1'b0; dbg_addr = 6'd0;
        @(negedge clk);
        #1;
        chk("dbgrd_entry0", 64'({dbg_ack, dbg_rgrubby, dbg_rdata}), 64'({1'b1, 1'b0, 32'd0}));
        dbg_req = 1'b0;

        // ---------------- debug gated by core_halted ----------------
        @(negedge clk);
        core_halted = 1'b0; dbg_req = 1'b1; dbg_write = 1'b1; dbg_addr = 6'd9; dbg_wdata = 32'hCAFEF00D;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("gated_idle", 64'({dbg_ack, core_stall}), 64'(2'b00));
        end
        @(negedge clk);
        core_halted = 1'b1;
        core_we = 1'b1; core_wa = 6'd9; core_wd = 32'h11111111;
        #1;
        chk("gated_accept", 64'({dbg_ack, core_stall}), 64'(2'b01));
        @(negedge clk);
        #1;
        chk("gated_ack", 64'({dbg_ack, core_stall}), 64'(2'b11));
        dbg_req = 1'b0; core_we = 1'b0; core_ra1 = 6'd9;
        @(negedge clk);
        #1;
        chk("gated_readback", 64'({core_rg1, core_rd1}), 64'({1'b0, 32'hCAFEF00D}));

        // ---------------- back-to-back debug writes ----------------
        @(negedge clk);
        dbg_req = 1'b1; dbg_write = 1'b1; dbg_addr = 6'd7; dbg_wdata = 32'h77777777;
        ack_idx0 = -1;
        ack_idx1 = -1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (dbg_ack) begin
                if (ack_idx0 < 0) begin
                    ack_idx0 = i;
                    dbg_addr = 6'd8; dbg_wdata = 32'h88888888;
                end else if (ack_idx1 < 0) begin
                    ack_idx1 = i;
                    dbg_req = 1'b0;
                end
            end
        end
        chk("b2b_first_ack", 64'(ack_idx0), 64'(1));
        chk("b2b_second_ack", 64'(ack_idx1), 64'(3));
        @(negedge clk);
        core_ra1 = 6'd7; core_ra2 = 6'd8;
        @(negedge clk);
        #1;
        chk("b2b_read7", 64'(core_rd1), 64'(32'h77777777));
        chk("b2b_read8", 64'(core_rd2), 64'(32'h88888888));

        // ---------------- reset mid-clear ----------------
        idle();
        core_halted = 1'b0;
        do_reset_clear(30);
        do_reset_clear(-1);

        // ---------------- randomized run against the scoreboard ----------------
        for (int i = 0; i < NREGS; i++) model[i] = 33'd0;
        ack_due = 1'b0; dbg_pend = 1'b0; r1_valid = 1'b0; r2_valid = 1'b0;
        cur_wr = 1'b0; cur_addr = '0; cur_wd = '0; exp_dbg = '0; exp_r1 = '0; exp_r2 = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) core_halted = ~core_halted;
            core_we  = 1'($urandom);
            core_wa  = 6'($urandom);
            core_wd  = 32'($urandom);
            core_wg  = 1'($urandom);
            core_ra1 = 6'($urandom);
            core_ra2 = 6'($urandom);
            if (!dbg_pend && ($urandom_range(3) == 0)) begin
                dbg_pend = 1'b1;
                cur_wr   = 1'($urandom);
                cur_addr = 6'($urandom);
                cur_wd   = 32'($urandom);
            end
            dbg_req = dbg_pend; dbg_write = cur_wr; dbg_addr = cur_addr; dbg_wdata = cur_wd;
            #1;
            if (r1_valid) chk("rnd_rd1", 64'({core_rg1, core_rd1}), 64'(exp_r1));
            if (r2_valid) chk("rnd_rd2", 64'({core_rg2, core_rd2}), 64'(exp_r2));
            exp_r1 = model[core_ra1];
            exp_r2 = model[core_ra2];
            r2_valid = 1'b1;
            if (ack_due) begin
                chk("rnd_ack", 64'({dbg_ack, core_stall}), 64'(2'b11));
                if (!cur_wr) chk("rnd_dbg_rdata", 64'({dbg_rgrubby, dbg_rdata}), 64'(exp_dbg));
                ack_due  = 1'b0;
                dbg_pend = 1'b0;
                r1_valid = 1'b1;
            end else begin
                accept = dbg_pend && core_halted;
                chk("rnd_stall", 64'({dbg_ack, core_stall}), 64'({1'b0, accept}));
                r1_valid = !(accept && !cur_wr);
                if (accept) begin
                    ack_due = 1'b1;
                    if (cur_wr) begin
                        if (cur_addr != '0) model[cur_addr] = {1'b0, cur_wd};
                    end else begin
                        exp_dbg = model[cur_addr];
                    end
                end else if (core_we && (core_wa != '0)) begin
                    model[core_wa] = {core_wg, core_wd};
                end
            end
        end
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regset_ctrl.md
# regset_ctrl

Sequencer and port arbiter in front of the 64-entry, 33-bit register set (32 data bits plus one grubby bit) used by the Pipeline core. After reset it zero-fills every entry so formal and simulation runs start from a defined state. It then passes core traffic through transparently, and services single-word debug reads and writes through the same ports while the core is halted. It sits between `Pipeline` (regset_* ports) and the register-set BRAM.

## Interface

Parameters:
- `NREGS`, 64: number of entries cleared after reset; power of two, at most 2^AW.
- `AW`, 6: register address width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `core_we`, `core_wa`[AW], `core_wd`[32], `core_wg`  in: core write port.
- `core_ra1`, `core_ra2`  in  AW  core read addresses.
- `core_rd1`, `core_rd2`  out  32  core read data; passed through from rs_rd1/rs_rd2.
- `core_rg1`, `core_rg2`  out  1  core grubby bits; passed through from rs_rg1/rs_rg2.
- `core_stall`  out  1  high while the core must not use the register set.
- `core_halted`  in  1  core is halted, so debug access is permitted.
- `init_done`  out  1  clear sequence finished.
- `dbg_req`, `dbg_write`  in  1  debug request and direction (1 = write).
- `dbg_addr`  in  AW  debug address.
- `dbg_wdata`  in  32  debug write data.
- `dbg_ack`  out  1  one-cycle completion pulse.
- `dbg_rdata`  out  32  debug read data, valid with dbg_ack.
- `dbg_rgrubby`  out  1  grubby bit of the read entry, valid with dbg_ack.
- `rs_we`, `rs_wa`[AW], `rs_wd`[32], `rs_wg`  out: register-set write port.
- `rs_ra1`, `rs_ra2`  out  AW  register-set read addresses.
- `rs_rd1`, `rs_rd2`[32], `rs_rg1`, `rs_rg2`  in: register-set synchronous read data, 1-cycle latency.

## Operation

State machine states: CLEAR, RUN, DBG.

- **CLEAR** (entered on reset):
  - A counter `cnt` runs 0..NREGS-1, one entry per cycle.
  - Drives rs_we=1, rs_wa=cnt, rs_wd=0, rs_wg=0.
  - core_stall=1; dbg_req is ignored.
  - After the write of NREGS-1, go to RUN.
- **RUN**:
  - All rs_* outputs are a combinational mux of the core_* ports; core_stall=0.
  - If dbg_req=1 and core_halted=1, accept the request, go to DBG, and latch dbg_write, dbg_addr and dbg_wdata.
  - In the accept cycle the debug access drives the rs_* ports instead of the core:
    - write: rs_we=1, rs_wa=dbg_addr, rs_wd=dbg_wdata, rs_wg=0.
    - read: rs_we=0, rs_ra1=dbg_addr.
- **DBG** (single cycle):
  - dbg_ack=1; for reads, dbg_rdata=rs_rd1 and dbg_rgrubby=rs_rg1.
  - Always return to RUN.
  - core_stall=1, and core writes are blocked (rs_we forced to 0 unless the access is a debug write).
- core_stall is high in CLEAR, in the accept cycle and in DBG; it is low otherwise.
- Address 0: the controller passes the write unchanged; the register set ignores writes to entry 0. A debug read of entry 0 returns 0.
- While core_halted=0, debug requests stay pending and the core is never stalled by debug.

## Timing

- Reset values:
  - state=CLEAR, cnt=0, init_done=0, dbg_ack=0, dbg_rdata=0, dbg_rgrubby=0.
  - core_stall=1.
  - rs_we=1 with rs_wa=0, since CLEAR begins immediately.
- Clear latency: NREGS cycles. init_done rises at the edge after the last clear write, i.e. in cycle NREGS after rstn deasserts, and stays high until the next reset.
- Debug latency: request accepted at cycle T; dbg_ack pulses at T+1.
- Handshake:
  - dbg_req must be held with stable address and data until dbg_ack.
  - The earliest next acceptance is T+2, because the DBG cycle never accepts, so back-to-back requests are spaced by 2 cycles.
- Reset mid-operation (in CLEAR or DBG): immediately restart CLEAR from cnt=0. A debug ack in flight is dropped.
- If core_halted falls while in DBG, the ack is still issued.

## Test plan

- **Reset clear.** Release rstn, NREGS=64.
  - rs_we=1 for exactly 64 cycles with rs_wa=0..63, rs_wd=0, rs_wg=0.
  - init_done=1 from cycle 64; core_stall drops in the same cycle.
- **Pass-through.** In RUN, core write of wa=5, wd=0xDEADBEEF, then read ra1=5.
  - The rs_* ports mirror the core ports.
  - core_rd1=0xDEADBEEF one cycle later.
- **Debug read while halted.** core_halted=1, dbg_req read of addr 5.
  - dbg_ack one cycle after acceptance with dbg_rdata=0xDEADBEEF and dbg_rgrubby=0.
  - core_stall=1 for 2 cycles.
- **Debug gated.** dbg_req write with core_halted=0 for 10 cycles: no ack and core_stall=0. Raise core_halted: ack 1 cycle after acceptance, and the register now holds dbg_wdata.
- **Back-to-back debug.** dbg_req held high across two writes to addr 7 then addr 8: acks spaced exactly 2 cycles apart, and both values read back correctly.
- **Reset mid-clear.** Assert rstn low at cnt=30, then release: the clear restarts at rs_wa=0 and init_done rises 64 cycles after release.
